// File: rtl/irq_pending_latch_pkg.sv
// Shared constants and types for the interrupt pending latch front-end.
package irq_pkg;

  // Default number of request lines and the matching encoder index width.
  localparam int N_IRQ    = 8;
  localparam int IRQ_IDXW = $clog2(N_IRQ);

  // IDLE: waiting for an enabled pending bit; PRESENT: snapshot frozen on pend_out.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } irq_state_t;

endpackage

// File: rtl/irq_pending_latch_if.sv
// Bundle of request, mask, handshake and status signals between the
// interrupt latch (slave) and the block driving / consuming it (master).
interface irq_pending_latch_if
  import irq_pkg::*;
#(
  parameter int N    = N_IRQ,
  parameter int IDXW = IRQ_IDXW
) ();

  logic [N-1:0]    irq_in;
  logic [N-1:0]    mask;
  logic            clr_all;
  logic            ack;
  logic [IDXW-1:0] ack_idx;
  logic [N-1:0]    pend_out;
  logic            irq_valid;
  logic [N-1:0]    pending_o;

  // Consumer / stimulus side.
  modport master (
    output irq_in,
    output mask,
    output clr_all,
    output ack,
    output ack_idx,
    input  pend_out,
    input  irq_valid,
    input  pending_o
  );

  // Latch side.
  modport slave (
    input  irq_in,
    input  mask,
    input  clr_all,
    input  ack,
    input  ack_idx,
    output pend_out,
    output irq_valid,
    output pending_o
  );

endinterface

// File: rtl/irq_pending_latch_sync_2ff.sv
// Vector two-flop synchroniser for request lines that are asynchronous to clk.
// Each bit is synchronised independently; no cross-bit coherency is implied.
module sync_2ff #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] meta_d;
  logic [W-1:0] sync_q;
  logic [W-1:0] sync_d;

  // Next values: shift the raw lines through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser stages, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Interrupt request front-end for an 8:3 priority encoder.
// Raw lines are synchronised, latched as pending bits (rising-edge or level
// mode), masked, and frozen into pend_out under a valid/ack handshake. The
// index returned on ack_idx clears the serviced pending bit in edge mode.
module irq_pending_latch
  import irq_pkg::*;
#(
  parameter int N         = N_IRQ,
  parameter int IDXW      = IRQ_IDXW,
  parameter bit EDGE_MODE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  irq_pending_latch_if.slave bus
);

  logic [N-1:0] s1;
  logic [N-1:0] prev_q;
  logic [N-1:0] prev_d;
  logic [N-1:0] edge_det;
  logic [N-1:0] pending_q;
  logic [N-1:0] pending_d;
  logic [N-1:0] pend_out_q;
  logic [N-1:0] pend_out_d;
  logic         irq_valid_q;
  logic         irq_valid_d;
  irq_state_t   state_q;
  irq_state_t   state_d;

  logic [N-1:0] ack_sel;
  logic [N-1:0] ack_clr;
  logic         ack_take;
  logic [N-1:0] req;

  sync_2ff #(
    .W (N)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.irq_in),
    .q     (s1)
  );

  // Rising-edge detect on the synchronised lines. prev always tracks s1, so a
  // flush also re-arms detection without producing an edge for held lines.
  always_comb begin
    prev_d   = s1;
    edge_det = s1 & ~prev_q;
  end

  // Decode the serviced index into a one-hot clear vector. An index at or
  // beyond N matches no line, and only bits actually presented may be
  // cleared, so a stray index completes the handshake without side effects.
  always_comb begin
    ack_sel = '0;
    for (int i = 0; i < N; i++) begin
      ack_sel[i] = (32'(bus.ack_idx) == 32'(i));
    end
    ack_take = (state_q == PRESENT) && bus.ack;
    ack_clr  = '0;
    if (ack_take && EDGE_MODE) begin
      ack_clr = ack_sel & pend_out_q;
    end
  end

  // Pending register update: flush first, then edge latch with set winning
  // over a same-cycle clear, or plain level follow.
  always_comb begin
    pending_d = pending_q;
    if (bus.clr_all) begin
      pending_d = '0;
    end else if (EDGE_MODE) begin
      pending_d = (pending_q & ~ack_clr) | edge_det;
    end else begin
      pending_d = s1;
    end
  end

  // Presentation FSM next state: snapshot enabled pending bits in IDLE, hold
  // them untouched in PRESENT until acknowledged. The mask only matters at
  // the moment of capture.
  always_comb begin
    req         = pending_q & bus.mask;
    state_d     = state_q;
    pend_out_d  = pend_out_q;
    irq_valid_d = irq_valid_q;
    if (bus.clr_all) begin
      state_d     = IDLE;
      pend_out_d  = '0;
      irq_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|req) begin
            pend_out_d  = req;
            irq_valid_d = 1'b1;
            state_d     = PRESENT;
          end
        end
        PRESENT: begin
          if (bus.ack) begin
            irq_valid_d = 1'b0;
            state_d     = IDLE;
          end
        end
        default: begin
          irq_valid_d = 1'b0;
          state_d     = IDLE;
        end
      endcase
    end
  end

  // Edge-detect and pending state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= prev_d;
      pending_q <= pending_d;
    end
  end

  // FSM state with registered snapshot and valid outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_out_q  <= '0;
      irq_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_out_q  <= pend_out_d;
      irq_valid_q <= irq_valid_d;
    end
  end

  assign bus.pend_out  = pend_out_q;
  assign bus.irq_valid = irq_valid_q;
  assign bus.pending_o = pending_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Bench for irq_pending_latch (edge mode): directed scenarios followed by
// randomized traffic against a behavioural model of the latch.
module tb_irq_pending_latch;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  irq_pending_latch_if #(.N(8), .IDXW(3)) bus ();

  irq_pending_latch #(
    .N         (8),
    .IDXW      (3),
    .EDGE_MODE (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Behavioural model: line history through the synchroniser, pending bits,
  // presented snapshot and its valid flag.
  bit [7:0] m_ff1, m_s1, m_prev, m_pend, m_snap;
  bit       m_valid;

  task automatic model_clear();
    m_ff1 = 0; m_s1 = 0; m_prev = 0; m_pend = 0; m_snap = 0; m_valid = 0;
  endtask

  // Advance one clock; the model applies the rules using pre-edge values.
  task automatic tick();
    bit [7:0] rise, np, ns;
    bit nv;
    @(posedge clk);
    rise = m_s1 & ~m_prev;
    np = m_pend; ns = m_snap; nv = m_valid;
    if (bus.clr_all) begin
      np = 0; ns = 0; nv = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (m_valid && bus.ack && int'(bus.ack_idx) == i && m_snap[i]) np[i] = 1'b0;
        if (rise[i]) np[i] = 1'b1;
      end
      if (!m_valid) begin
        if ((m_pend & bus.mask) != 0) begin
          ns = m_pend & bus.mask;
          nv = 1'b1;
        end
      end else if (bus.ack) begin
        nv = 1'b0;
      end
    end
    m_pend = np; m_snap = ns; m_valid = nv;
    m_prev = m_s1; m_s1 = m_ff1; m_ff1 = bus.irq_in;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (bus.irq_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic pulse(input bit [7:0] lines);
    bus.irq_in = lines;
    tick();
    bus.irq_in = 8'h00;
  endtask

  task automatic do_ack(input bit [2:0] idx);
    bus.ack = 1'b1; bus.ack_idx = idx;
    tick();
    bus.ack = 1'b0;
  endtask

  function automatic bit [2:0] top_idx(input bit [7:0] v);
    top_idx = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) top_idx = 3'(i);
  endfunction

  task automatic test_reset();
    bus.irq_in = 0; bus.mask = 8'hFF; bus.clr_all = 0; bus.ack = 0; bus.ack_idx = 0;
    rst_n = 1'b0;
    #1;
    nvec++; if (bus.pend_out !== 8'h00) begin nerr++; $display("FAIL reset_pend_out got %h want 00", bus.pend_out); end
    nvec++; if (bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got %b want 0", bus.irq_valid); end
    nvec++; if (bus.pending_o !== 8'h00) begin nerr++; $display("FAIL reset_pending got %h want 00", bus.pending_o); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    ticks(2);
  endtask

  task automatic test_single_pulse();
    bus.mask = 8'hFF;
    pulse(8'h20);
    ticks(2);
    nvec++; if (bus.pending_o !== 8'h20) begin nerr++; $display("FAIL t1_pending_e2 got %h want 20", bus.pending_o); end
    nvec++; if (bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL t1_valid_e2 got %b want 0", bus.irq_valid); end
    tick();
    nvec++; if (bus.irq_valid !== 1'b1) begin nerr++; $display("FAIL t1_valid_e3 got %b want 1", bus.irq_valid); end
    nvec++; if (bus.pend_out !== 8'h20) begin nerr++; $display("FAIL t1_pend_out got %h want 20", bus.pend_out); end
    do_ack(3'd5);
    nvec++; if (bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL t1_valid_ack got %b want 0", bus.irq_valid); end
    nvec++; if (bus.pending_o !== 8'h00) begin nerr++; $display("FAIL t1_pending_ack got %h want 00", bus.pending_o); end
    ticks(2);
  endtask

  task automatic test_two_lines();
    bit ok;
    pulse(8'h81);
    wait_valid(6, ok);
    nvec++; if (!ok) begin nerr++; $display("FAIL t2_wait valid got 0 want 1"); end
    nvec++; if (bus.pend_out !== 8'h81) begin nerr++; $display("FAIL t2_pend_out got %h want 81", bus.pend_out); end
    do_ack(3'd7);
    nvec++; if (bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL t2_gap got %b want 0", bus.irq_valid); end
    nvec++; if (bus.pending_o !== 8'h01) begin nerr++; $display("FAIL t2_pending got %h want 01", bus.pending_o); end
    tick();
    nvec++; if (bus.irq_valid !== 1'b1) begin nerr++; $display("FAIL t2_revalid got %b want 1", bus.irq_valid); end
    nvec++; if (bus.pend_out !== 8'h01) begin nerr++; $display("FAIL t2_pend_out2 got %h want 01", bus.pend_out); end
    do_ack(3'd0);
    ticks(2);
    nvec++; if (bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL t2_idle got %b want 0", bus.irq_valid); end
    nvec++; if (bus.pending_o !== 8'h00) begin nerr++; $display("FAIL t2_pending_end got %h want 00", bus.pending_o); end
  endtask

  task automatic test_frozen_snapshot();
    bit ok;
    pulse(8'h02);
    wait_valid(6, ok);
    nvec++; if (bus.pend_out !== 8'h02) begin nerr++; $display("FAIL t3_pend_out got %h want 02", bus.pend_out); end
    pulse(8'h08);
    ticks(4);
    nvec++; if (bus.pend_out !== 8'h02) begin nerr++; $display("FAIL t3_frozen got %h want 02", bus.pend_out); end
    nvec++; if (bus.pending_o !== 8'h0A) begin nerr++; $display("FAIL t3_pending got %h want 0a", bus.pending_o); end
    do_ack(3'd1);
    tick();
    nvec++; if (bus.pend_out !== 8'h08 || bus.irq_valid !== 1'b1) begin nerr++; $display("FAIL t3_next got %h/%b want 08/1", bus.pend_out, bus.irq_valid); end
    do_ack(3'd3);
    ticks(2);
  endtask

  task automatic test_ack_mismatch();
    bit ok;
    pulse(8'h06);
    wait_valid(6, ok);
    nvec++; if (bus.pend_out !== 8'h06) begin nerr++; $display("FAIL t_mis_pend_out got %h want 06", bus.pend_out); end
    do_ack(3'd5);
    nvec++; if (bus.irq_valid !== 1'b0 || bus.pending_o !== 8'h06) begin nerr++; $display("FAIL t_mis_drop got %b/%h want 0/06", bus.irq_valid, bus.pending_o); end
    tick();
    nvec++; if (bus.pend_out !== 8'h06 || bus.irq_valid !== 1'b1) begin nerr++; $display("FAIL t_mis_repres got %h/%b want 06/1", bus.pend_out, bus.irq_valid); end
    do_ack(3'd2);
    tick();
    do_ack(3'd1);
    ticks(2);
    nvec++; if (bus.pending_o !== 8'h00) begin nerr++; $display("FAIL t_mis_end got %h want 00", bus.pending_o); end
  endtask

  task automatic test_mask();
    bit ok;
    bus.mask = 8'hFE;
    pulse(8'h01);
    ticks(5);
    nvec++; if (bus.pending_o !== 8'h01) begin nerr++; $display("FAIL t4_pending got %h want 01", bus.pending_o); end
    nvec++; if (bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL t4_masked got %b want 0", bus.irq_valid); end
    do_ack(3'd0);
    nvec++; if (bus.pending_o !== 8'h01) begin nerr++; $display("FAIL t4_idle_ack got %h want 01", bus.pending_o); end
    bus.mask = 8'hFF;
    wait_valid(3, ok);
    nvec++; if (!ok || bus.pend_out !== 8'h01) begin nerr++; $display("FAIL t4_unmask got %b/%h want 1/01", ok, bus.pend_out); end
    do_ack(3'd0);
    ticks(2);
  endtask

  task automatic test_set_wins();
    bit ok;
    pulse(8'h10);
    wait_valid(6, ok);
    nvec++; if (bus.pend_out !== 8'h10) begin nerr++; $display("FAIL t5_pend_out got %h want 10", bus.pend_out); end
    bus.irq_in = 8'h10;
    ticks(2);
    bus.ack = 1'b1; bus.ack_idx = 3'd4;
    tick();
    bus.ack = 1'b0; bus.irq_in = 8'h00;
    nvec++; if (bus.pending_o[4] !== 1'b1) begin nerr++; $display("FAIL t5_set_wins got %b want 1", bus.pending_o[4]); end
    nvec++; if (bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL t5_gap got %b want 0", bus.irq_valid); end
    tick();
    nvec++; if (bus.pend_out !== 8'h10 || bus.irq_valid !== 1'b1) begin nerr++; $display("FAIL t5_repres got %h/%b want 10/1", bus.pend_out, bus.irq_valid); end
    do_ack(3'd4);
    ticks(2);
  endtask

  task automatic test_clr_all();
    bit ok;
    bus.irq_in = 8'hC3;
    wait_valid(6, ok);
    nvec++; if (bus.pend_out !== 8'hC3 || bus.pending_o !== 8'hC3) begin nerr++; $display("FAIL t6_pres got %h/%h want c3/c3", bus.pend_out, bus.pending_o); end
    bus.clr_all = 1'b1;
    tick();
    bus.clr_all = 1'b0;
    nvec++; if (bus.pend_out !== 8'h00 || bus.irq_valid !== 1'b0 || bus.pending_o !== 8'h00) begin nerr++; $display("FAIL t6_clr got %h/%b/%h want 00/0/00", bus.pend_out, bus.irq_valid, bus.pending_o); end
    ticks(5);
    nvec++; if (bus.pending_o !== 8'h00 || bus.irq_valid !== 1'b0) begin nerr++; $display("FAIL t6_no_edge got %h/%b want 00/0", bus.pending_o, bus.irq_valid); end
    bus.irq_in = 8'h00;
    ticks(3);
  endtask

  task automatic test_async_reset();
    bit ok;
    bus.irq_in = 8'h04;
    wait_valid(6, ok);
    nvec++; if (bus.pend_out !== 8'h04) begin nerr++; $display("FAIL t7_pres got %h want 04", bus.pend_out); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (bus.pend_out !== 8'h00 || bus.irq_valid !== 1'b0 || bus.pending_o !== 8'h00) begin nerr++; $display("FAIL t7_async got %h/%b/%h want 00/0/00", bus.pend_out, bus.irq_valid, bus.pending_o); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    wait_valid(6, ok);
    nvec++; if (!ok || bus.pend_out !== 8'h04) begin nerr++; $display("FAIL t7_held_edge got %b/%h want 1/04", ok, bus.pend_out); end
    do_ack(3'd2);
    ticks(5);
    nvec++; if (bus.irq_valid !== 1'b0 || bus.pending_o !== 8'h00) begin nerr++; $display("FAIL t7_one_edge got %b/%h want 0/00", bus.irq_valid, bus.pending_o); end
    bus.irq_in = 8'h00;
    ticks(3);
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 2) == 0) bus.irq_in[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) bus.mask = 8'($urandom);
      bus.clr_all = ($urandom_range(0, 59) == 0);
      bus.ack     = ($urandom_range(0, 2) == 0);
      bus.ack_idx = ($urandom_range(0, 3) == 0) ? 3'($urandom) : top_idx(m_snap);
      tick();
      nvec++; if (bus.irq_valid !== m_valid) begin nerr++; $display("FAIL rnd_valid cyc %0d got %b want %b", n, bus.irq_valid, m_valid); end
      nvec++; if (bus.pend_out !== m_snap) begin nerr++; $display("FAIL rnd_pend_out cyc %0d got %h want %h", n, bus.pend_out, m_snap); end
      nvec++; if (bus.pending_o !== m_pend) begin nerr++; $display("FAIL rnd_pending cyc %0d got %h want %h", n, bus.pending_o, m_pend); end
    end
    bus.clr_all = 1'b0; bus.ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_two_lines();
    test_frozen_snapshot();
    test_ack_mismatch();
    test_mask();
    test_set_wins();
    test_clr_all();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
